// File: rtl/dsp_mac_core.sv
// dsp_mac_core
//   Five-stage fixed-point multiply/accumulate core with the stages decode,
//   read, ex1, ex2 and writeback. The pipeline advances every clock and never
//   stalls.
//   Instruction word, MSB first: {opcode, sample_addr, param_addr}.
//   Opcodes: NOP 0, MUL 1, MAC 2, ROTMAC 3, STORE 4, IN 5, OUT 6. Any other
//   opcode is treated as a NOP.
//
// Ports
//   clk, reset_n              clock; asynchronous active-low reset
//   instr_valid, instruction  instruction issue; instr_valid low issues a NOP
//   sample_rd_addr/_data      sample memory read port (1-cycle latency)
//   param_rd_addr/_data       parameter memory read port (1-cycle latency)
//   io_rd_addr/_data          IO memory read port (1-cycle latency)
//   sample_wr_en/_addr/_data  sample memory write port
//   io_wr_en/_addr/_data      IO memory write port
//   ring_bus_in/_out          inter-core accumulator link; ring_bus_out is A
//   sat_clear, sat_flag       sticky saturation flag and its clear
//
// Build option
//   DSP_MAC_CORE_DITHER_EN    when defined, OUT adds LFSR dither below the IO
//                             LSB before IO saturation. When undefined, OUT
//                             truncates toward minus infinity.
module dsp_mac_core #(
  parameter int SAMPLE_WIDTH      = 36,
  parameter int SAMPLE_FRAC_BITS  = 30,
  parameter int PARAM_WIDTH       = 36,
  parameter int PARAM_FRAC_BITS   = 30,
  parameter int IO_WIDTH          = 24,
  parameter int IO_FRAC_BITS      = 20,
  parameter int OPCODE_WIDTH      = 6,
  parameter int SAMPLE_ADDR_WIDTH = 10,
  parameter int PARAM_ADDR_WIDTH  = 10,
  parameter int LFSR_WIDTH        = 36,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLYNOMIAL = 36'h80000003B,
  localparam int ACCUM_WIDTH      = SAMPLE_WIDTH + PARAM_WIDTH,
  localparam int ACCUM_FRAC_BITS  = SAMPLE_FRAC_BITS + PARAM_FRAC_BITS,
  localparam int INSTR_WIDTH      = OPCODE_WIDTH + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         instr_valid,
  input  logic [INSTR_WIDTH-1:0]       instruction,
  output logic [SAMPLE_ADDR_WIDTH-1:0] sample_rd_addr,
  input  logic [SAMPLE_WIDTH-1:0]      sample_rd_data,
  output logic [PARAM_ADDR_WIDTH-1:0]  param_rd_addr,
  input  logic [PARAM_WIDTH-1:0]       param_rd_data,
  output logic [PARAM_ADDR_WIDTH-1:0]  io_rd_addr,
  input  logic [IO_WIDTH-1:0]          io_rd_data,
  output logic                         sample_wr_en,
  output logic [SAMPLE_ADDR_WIDTH-1:0] sample_wr_addr,
  output logic [SAMPLE_WIDTH-1:0]      sample_wr_data,
  output logic                         io_wr_en,
  output logic [PARAM_ADDR_WIDTH-1:0]  io_wr_addr,
  output logic [IO_WIDTH-1:0]          io_wr_data,
  input  logic [ACCUM_WIDTH-1:0]       ring_bus_in,
  output logic [ACCUM_WIDTH-1:0]       ring_bus_out,
  input  logic                         sat_clear,
  output logic                         sat_flag
);

  localparam int SAMPLE_SHIFT = ACCUM_FRAC_BITS - SAMPLE_FRAC_BITS;
  localparam int IO_SHIFT     = ACCUM_FRAC_BITS - IO_FRAC_BITS;
  localparam int DITHER_BITS  = (LFSR_WIDTH < IO_SHIFT) ? LFSR_WIDTH : IO_SHIFT;
  // Guard widths include the sign bit of the slice that is kept.
  localparam int S_GUARD      = ACCUM_WIDTH - SAMPLE_SHIFT - SAMPLE_WIDTH + 1;
  localparam int IO_GUARD     = ACCUM_WIDTH - IO_SHIFT - IO_WIDTH + 1;
  localparam int IO_PAD       = PARAM_WIDTH - IO_WIDTH;
  localparam int IO_ALIGN     = PARAM_FRAC_BITS - IO_FRAC_BITS;
  localparam logic [SAMPLE_WIDTH-1:0] S_MAX  = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic [SAMPLE_WIDTH-1:0] S_MIN  = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [IO_WIDTH-1:0]     IO_MAX = {1'b0, {(IO_WIDTH-1){1'b1}}};
  localparam logic [IO_WIDTH-1:0]     IO_MIN = {1'b1, {(IO_WIDTH-1){1'b0}}};

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP    = 'd0,
    OP_MUL    = 'd1,
    OP_MAC    = 'd2,
    OP_ROTMAC = 'd3,
    OP_STORE  = 'd4,
    OP_IN     = 'd5,
    OP_OUT    = 'd6
  } opcode_e;

  logic [INSTR_WIDTH-1:0] dec_ir, rd_ir, ex1_ir, ex2_ir, wb_ir;
  opcode_e ex1_op, ex2_op, wb_op;

  // Unknown opcodes and unqualified slots become all-zero NOPs at decode, so
  // the later stages only ever see legal opcodes.
  always_comb begin
    dec_ir = '0;
    if (instr_valid) begin
      case (instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH])
        OP_MUL, OP_MAC, OP_ROTMAC, OP_STORE, OP_IN, OP_OUT: dec_ir = instruction;
        default: dec_ir = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ir  <= '0;
      ex1_ir <= '0;
      ex2_ir <= '0;
      wb_ir  <= '0;
    end else begin
      rd_ir  <= dec_ir;
      ex1_ir <= rd_ir;
      ex2_ir <= ex1_ir;
      wb_ir  <= ex2_ir;
    end
  end

  assign ex1_op = opcode_e'(ex1_ir[INSTR_WIDTH-1 -: OPCODE_WIDTH]);
  assign ex2_op = opcode_e'(ex2_ir[INSTR_WIDTH-1 -: OPCODE_WIDTH]);
  assign wb_op  = opcode_e'(wb_ir[INSTR_WIDTH-1 -: OPCODE_WIDTH]);

  assign sample_rd_addr = rd_ir[PARAM_ADDR_WIDTH +: SAMPLE_ADDR_WIDTH];
  assign param_rd_addr  = rd_ir[PARAM_ADDR_WIDTH-1:0];
  assign io_rd_addr     = rd_ir[PARAM_ADDR_WIDTH-1:0];

  // IN reuses the multiplier: 1.0 times the IO word realigned to parameter
  // format, so the IO value lands in A with accumulator scaling.
  logic [SAMPLE_WIDTH-1:0] mul_a;
  logic [PARAM_WIDTH-1:0]  mul_b;
  logic signed [ACCUM_WIDTH-1:0] m_next, m_reg, a_next, a_reg;

  always_comb begin
    mul_a = sample_rd_data;
    mul_b = param_rd_data;
    if (ex1_op == OP_IN) begin
      mul_a = SAMPLE_WIDTH'(1) << SAMPLE_FRAC_BITS;
      mul_b = {{IO_PAD{io_rd_data[IO_WIDTH-1]}}, io_rd_data} << IO_ALIGN;
    end
  end

  assign m_next = $signed({{PARAM_WIDTH{mul_a[SAMPLE_WIDTH-1]}}, mul_a})
                * $signed({{SAMPLE_WIDTH{mul_b[PARAM_WIDTH-1]}}, mul_b});

  always_comb begin
    a_next = a_reg;
    case (ex2_op)
      OP_MUL, OP_IN: a_next = m_reg;
      OP_MAC:        a_next = a_reg + m_reg;
      OP_ROTMAC:     a_next = $signed(ring_bus_in) + m_reg;
      default:       a_next = a_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reg <= '0;
      a_reg <= '0;
    end else begin
      m_reg <= m_next;
      a_reg <= a_next;
    end
  end

  assign ring_bus_out = a_reg;

  // A is already updated by the time the preceding instruction reaches
  // writeback, so STORE/OUT right behind an arithmetic op need no bypass.
  logic [LFSR_WIDTH-1:0]  lfsr;
  logic [ACCUM_WIDTH-1:0] dither, io_sum;
  logic [S_GUARD-1:0]     s_guard;
  logic [IO_GUARD-1:0]    io_guard;
  logic                   s_ovf, io_ovf, clamp;
  logic [SAMPLE_WIDTH-1:0] sat_s;
  logic [IO_WIDTH-1:0]     sat_io;

`ifdef DSP_MAC_CORE_DITHER_EN
  assign dither = {{(ACCUM_WIDTH-DITHER_BITS){1'b0}}, lfsr[LFSR_WIDTH-1 -: DITHER_BITS]}
                  << (IO_SHIFT - DITHER_BITS);
`else
  assign dither = '0;
`endif

  assign io_sum   = a_reg + dither;
  assign s_guard  = a_reg[ACCUM_WIDTH-1 -: S_GUARD];
  assign io_guard = io_sum[ACCUM_WIDTH-1 -: IO_GUARD];
  assign s_ovf    = !((&s_guard) || !(|s_guard));
  assign io_ovf   = !((&io_guard) || !(|io_guard));
  assign sat_s    = s_ovf ? (a_reg[ACCUM_WIDTH-1] ? S_MIN : S_MAX)
                          : a_reg[SAMPLE_SHIFT +: SAMPLE_WIDTH];
  assign sat_io   = io_ovf ? (io_sum[ACCUM_WIDTH-1] ? IO_MIN : IO_MAX)
                           : io_sum[IO_SHIFT +: IO_WIDTH];

  assign sample_wr_en   = (wb_op == OP_STORE) || (wb_op == OP_IN);
  assign sample_wr_addr = wb_ir[PARAM_ADDR_WIDTH +: SAMPLE_ADDR_WIDTH];
  assign sample_wr_data = sat_s;
  assign io_wr_en       = (wb_op == OP_OUT);
  assign io_wr_addr     = wb_ir[PARAM_ADDR_WIDTH-1:0];
  assign io_wr_data     = sat_io;
  assign clamp          = (sample_wr_en && s_ovf) || (io_wr_en && io_ovf);

  // A new clamp takes priority over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       sat_flag <= 1'b0;
    else if (clamp)     sat_flag <= 1'b1;
    else if (sat_clear) sat_flag <= 1'b0;
  end

  // Right-shift Galois LFSR; it runs in both builds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     lfsr <= LFSR_POLYNOMIAL;
    else if (lfsr[0]) lfsr <= (lfsr >> 1) ^ LFSR_POLYNOMIAL;
    else              lfsr <= lfsr >> 1;
  end

endmodule
